pc_fetch_unit: RTL and testbench

//  Owns the architectural PC and drives instruction fetch; consumer end of the next-PC

---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC, issues one-outstanding instruction
// fetches and buffers returned words in a small FIFO toward decode.
// Optional feature: define FETCH_EXC_EN to add the exc_valid input, which
// redirects fetch to 32'h0000_4180 with priority over redirect_valid.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned FB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_EXC_EN
    input  logic        exc_valid,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    localparam int unsigned PW = $clog2(FB_DEPTH);
    localparam int unsigned CW = $clog2(FB_DEPTH) + 1;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t         state;
    logic [31:0]    pc;

    logic [31:0]    fb_pc    [FB_DEPTH];
    logic [31:0]    fb_instr [FB_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic           redir;
    logic [31:0]    redir_target;
    logic           push;
    logic           pop;
    logic           flush;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(FB_DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    // Select the redirect source: exception target outranks next-PC logic.
    always_comb begin
        redir        = redirect_valid;
        redir_target = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_EXC_EN
        if (exc_valid) begin
            redir        = 1'b1;
            redir_target = EXC_PC;
        end
`endif
    end

    // FIFO control: push accepted acks, pop on handshake, flush on in-flight redirect.
    always_comb begin
        push  = (state == S_WAIT) && imem_ack && !redir;
        flush = (state != S_IDLE) && redir;
        pop   = (count != '0) && if_ready && !flush;
    end

    // Fetch FSM with registered request/address outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (redir) begin
                        pc <= redir_target;
                    end else if (count < CW'(FB_DEPTH)) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redir) begin
                        pc <= redir_target;
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            state    <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc       <= pc + 32'd4;
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (redir)
                        pc <= redir_target;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Fetch buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FB_DEPTH; i++) begin
                fb_pc[i]    <= '0;
                fb_instr[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fb_pc[wr_ptr]    <= pc;
                fb_instr[wr_ptr] <= imem_rdata;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    assign if_valid = (count != '0);
    assign if_instr = fb_instr[rd_ptr];
    assign if_pc    = fb_pc[rd_ptr];
    assign if_pc4   = if_pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit (default FB_DEPTH=2,
// RESET_PC=0x3000). Inputs change and outputs are sampled on the falling edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .FB_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_EXC_EN
        .exc_valid      (exc_valid),
`endif
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) until a request is visible at a falling edge.
    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, {31'd0, imem_req}, 32'd1);
    endtask

    // Answer the outstanding request after 'extra' additional cycles.
    task automatic serve(input int unsigned extra, input logic [31:0] data);
        repeat (extra) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exc_valid      = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_addr",   imem_addr, 32'd0);
        chk("rst_valid",  {31'd0, if_valid}, 32'd0);
        chk("rst_instr",  if_instr, 32'd0);
        chk("rst_pc",     if_pc, 32'd0);
        chk("rst_pc4",    if_pc4, 32'd4);

        // T1: first request the cycle after release, then async reset mid-wait
        rst_n = 1'b1;
        tick();
        chk("t1_req",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0000_3000);
        rst_n = 1'b0;
        #1;
        chk("t1_async_req",   {31'd0, imem_req}, 32'd0);
        chk("t1_async_valid", {31'd0, if_valid}, 32'd0);
        chk("t1_async_addr",  imem_addr, 32'd0);
        tick();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;          // stray ack while idle must be ignored
        imem_rdata = 32'hFFFF_0000;
        tick();
        imem_ack = 1'b0;
        chk("t1_rel_req",   {31'd0, imem_req}, 32'd1);
        chk("t1_rel_addr",  imem_addr, 32'h0000_3000);
        chk("t1_stray_ack", {31'd0, if_valid}, 32'd0);

        // T2: streaming with prompt acks and decode always ready
        for (int i = 0; i < 3; i++) begin
            wait_req("t2");
            chk("t2_addr", imem_addr, 32'h0000_3000 + 32'(4 * i));
            serve(0, 32'h1000_0000 + 32'(i));
            chk("t2_valid", {31'd0, if_valid}, 32'd1);
            chk("t2_pc",    if_pc,    32'h0000_3000 + 32'(4 * i));
            chk("t2_pc4",   if_pc4,   32'h0000_3004 + 32'(4 * i));
            chk("t2_instr", if_instr, 32'h1000_0000 + 32'(i));
        end

        // T3: stall decode; exactly two words buffered, no further request
        if_ready = 1'b0;            // word 0x3008 stays at head
        wait_req("t3");
        chk("t3_addr", imem_addr, 32'h0000_300C);
        serve(0, 32'h1000_0003);
        for (int i = 0; i < 3; i++) begin
            chk("t3_full_noreq", {31'd0, imem_req}, 32'd0);
            chk("t3_head_pc",    if_pc, 32'h0000_3008);
            tick();
        end
        if_ready = 1'b1;
        tick();
        chk("t3_pop_pc",    if_pc,    32'h0000_300C);
        chk("t3_pop_instr", if_instr, 32'h1000_0003);
        chk("t3_pop_noreq", {31'd0, imem_req}, 32'd0);
        tick();
        chk("t3_resume_req",  {31'd0, imem_req}, 32'd1);
        chk("t3_resume_addr", imem_addr, 32'h0000_3010);
        chk("t3_empty",       {31'd0, if_valid}, 32'd0);

        // T4: redirect in S_WAIT, ack arrives three cycles later and is dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3103;
        tick();
        redirect_valid = 1'b0;
        chk("t4_discard_req",  {31'd0, imem_req}, 32'd1);
        chk("t4_discard_addr", imem_addr, 32'h0000_3010);
        chk("t4_empty0",       {31'd0, if_valid}, 32'd0);
        tick();
        chk("t4_empty1", {31'd0, if_valid}, 32'd0);
        serve(1, 32'hDEAD_BEEF);
        chk("t4_dropped",   {31'd0, if_valid}, 32'd0);
        chk("t4_idle_req",  {31'd0, imem_req}, 32'd0);
        tick();
        chk("t4_new_req",  {31'd0, imem_req}, 32'd1);
        chk("t4_new_addr", imem_addr, 32'h0000_3100);

        // T5: redirect in the same cycle as the ack
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        serve(0, 32'hBAD0_0001);
        redirect_valid = 1'b0;
        chk("t5_not_pushed", {31'd0, if_valid}, 32'd0);
        chk("t5_req_low",    {31'd0, imem_req}, 32'd0);
        tick();
        chk("t5_new_req",  {31'd0, imem_req}, 32'd1);
        chk("t5_new_addr", imem_addr, 32'h0000_2000);
        serve(0, 32'h2000_0000);
        chk("t5_pc",    if_pc,    32'h0000_2000);
        chk("t5_instr", if_instr, 32'h2000_0000);

        // PC wrap: redirect to the last word, pc+4 wraps to zero
        wait_req("wrap");
        chk("wrap_seq_addr", imem_addr, 32'h0000_2004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        serve(0, 32'hBAD0_0002);
        redirect_valid = 1'b0;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        serve(0, 32'h3000_0000);
        chk("wrap_pc",  if_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc4, 32'h0000_0000);
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        serve(0, 32'h3000_0001);
        chk("wrap_next_pc", if_pc, 32'h0000_0000);

        // Redirect while idle: pc reloads, fetch resumes at the target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        tick();
        redirect_valid = 1'b0;
        chk("idle_redir_noreq", {31'd0, imem_req}, 32'd0);
        tick();
        chk("idle_redir_addr", imem_addr, 32'h0000_5000);

`ifdef FETCH_EXC_EN
        // T6: exception outranks redirect_valid
        exc_valid      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6000;
        tick();
        exc_valid      = 1'b0;
        redirect_valid = 1'b0;
        serve(0, 32'hBAD0_0003);
        chk("t6_dropped", {31'd0, if_valid}, 32'd0);
        tick();
        chk("t6_exc_addr", imem_addr, 32'h0000_4180);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
